// File: rtl/cu_pkg.sv
// Shared constants for the accumulator-processor control unit: control-word layout,
// bus/ALU codes, opcodes, FSM states and instruction classes.
package cu_pkg;

  localparam int unsigned CW_W       = 23;
  localparam int unsigned BUS_W      = 6;
  localparam int unsigned ALU_W      = 2;

  // Control-word bit positions
  localparam int unsigned CW_BUS_LSB = 2;
  localparam int unsigned CW_BUS_MSB = 7;
  localparam int unsigned CW_ALU_LSB = 8;
  localparam int unsigned CW_ALU_MSB = 9;
  localparam int unsigned CW_PC_INC  = 10;
  localparam int unsigned CW_R_LD    = 14;
  localparam int unsigned CW_AR_LD   = 15;
  localparam int unsigned CW_DR_LD   = 16;
  localparam int unsigned CW_AC_LD   = 17;
  localparam int unsigned CW_PC_LD   = 18;
  localparam int unsigned CW_IR_LD   = 19;
  localparam int unsigned CW_DRAM_RD = 20;
  localparam int unsigned CW_DRAM_WR = 21;
  localparam int unsigned CW_AC_SRC  = 22;

  localparam logic [BUS_W-1:0] BUS_NONE = 6'd0;
  localparam logic [BUS_W-1:0] BUS_AR   = 6'd1;
  localparam logic [BUS_W-1:0] BUS_PC   = 6'd2;
  localparam logic [BUS_W-1:0] BUS_IR   = 6'd3;
  localparam logic [BUS_W-1:0] BUS_DR   = 6'd4;
  localparam logic [BUS_W-1:0] BUS_R    = 6'd5;
  localparam logic [BUS_W-1:0] BUS_AC   = 6'd6;
  localparam logic [BUS_W-1:0] BUS_DRAM = 6'd7;
  localparam logic [BUS_W-1:0] BUS_IRAM = 6'd8;

  localparam logic [ALU_W-1:0] ALU_PASS = 2'b00;
  localparam logic [ALU_W-1:0] ALU_ADD  = 2'b01;
  localparam logic [ALU_W-1:0] ALU_SUB  = 2'b10;
  localparam logic [ALU_W-1:0] ALU_INC  = 2'b11;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LDAC  = 8'h01;
  localparam logic [7:0] OP_STAC  = 8'h02;
  localparam logic [7:0] OP_MVACR = 8'h03;
  localparam logic [7:0] OP_MVRAC = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_SUB   = 8'h06;
  localparam logic [7:0] OP_INAC  = 8'h07;
  localparam logic [7:0] OP_JUMP  = 8'h08;
  localparam logic [7:0] OP_JMPZ  = 8'h09;
  localparam logic [7:0] OP_JPNZ  = 8'h0A;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEMRD,
    S_LDAC2, S_MEMWR, S_JMP, S_SKIP, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    IC_NOP, IC_REG, IC_MEM_RD, IC_MEM_WR, IC_JMP,
    IC_JZ, IC_JNZ, IC_HALT, IC_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier feeding the control-unit sequencer.
module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned OPC_W = 8
) (
  input  logic [OPC_W-1:0] opcode,
  output iclass_t          iclass_c
);

  always_comb begin
    iclass_c = IC_ILLEGAL;
    case (opcode)
      OPC_W'(OP_NOP):   iclass_c = IC_NOP;
      OPC_W'(OP_LDAC):  iclass_c = IC_MEM_RD;
      OPC_W'(OP_STAC):  iclass_c = IC_MEM_WR;
      OPC_W'(OP_MVACR),
      OPC_W'(OP_MVRAC),
      OPC_W'(OP_ADD),
      OPC_W'(OP_SUB),
      OPC_W'(OP_INAC):  iclass_c = IC_REG;
      OPC_W'(OP_JUMP):  iclass_c = IC_JMP;
      OPC_W'(OP_JMPZ):  iclass_c = IC_JZ;
      OPC_W'(OP_JPNZ):  iclass_c = IC_JNZ;
      OPC_W'(OP_HALT):  iclass_c = IC_HALT;
      default:          iclass_c = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the 23-bit datapath control word.
// Define CU_ILLEGAL_TRAP_EN to halt on an undefined opcode instead of treating it as NOP.
module proc_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned IR_W  = 16,
  parameter int unsigned OPC_W = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [IR_W-1:0] ir,
  input  logic            ac_zero,
  input  logic            mem_ready,
  output logic [CW_W-1:0] control,
  output logic            halted,
  output logic            illegal
);

  state_t           state, state_nx;
  iclass_t          iclass;
  logic [OPC_W-1:0] opcode;
  logic [CW_W-1:0]  cw;
  logic             illegal_set;

  assign opcode  = ir[OPC_W-1:0];
  assign control = cw;

  generate
    if (IR_W > OPC_W) begin : g_ir_hi
      logic ir_hi_unused;
      assign ir_hi_unused = ^ir[IR_W-1:OPC_W];
    end
  endgenerate

  cu_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode   (opcode),
    .iclass_c (iclass)
  );

  // State, halt and sticky illegal registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state  <= state_nx;
      halted <= (state_nx == S_HALT);
      if (illegal_set) illegal <= 1'b1;
    end
  end

  // Next state and control word; control depends on mem_ready only in the memory states
  always_comb begin
    state_nx    = state;
    cw          = '0;
    illegal_set = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_FETCH;
      S_FETCH: begin
        cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_IRAM;
        cw[CW_IR_LD]              = 1'b1;
        cw[CW_PC_INC]             = 1'b1;
        state_nx                  = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          IC_NOP:               state_nx = S_FETCH;
          IC_REG:               state_nx = S_EXEC;
          IC_MEM_RD, IC_MEM_WR: state_nx = S_ADDR;
          IC_JMP:               state_nx = S_JMP;
          IC_JZ:                state_nx = ac_zero ? S_JMP : S_SKIP;
          IC_JNZ:               state_nx = ac_zero ? S_SKIP : S_JMP;
          IC_HALT:              state_nx = S_HALT;
          default: begin
            illegal_set = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
            state_nx    = S_HALT;
`else
            state_nx    = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        case (opcode)
          OPC_W'(OP_MVACR): begin
            cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_AC;
            cw[CW_R_LD]               = 1'b1;
          end
          OPC_W'(OP_MVRAC): begin
            cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_R;
            cw[CW_AC_LD]              = 1'b1;
          end
          OPC_W'(OP_ADD): begin
            cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_R;
            cw[CW_ALU_MSB:CW_ALU_LSB] = ALU_ADD;
            cw[CW_AC_LD]              = 1'b1;
            cw[CW_AC_SRC]             = 1'b1;
          end
          OPC_W'(OP_SUB): begin
            cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_R;
            cw[CW_ALU_MSB:CW_ALU_LSB] = ALU_SUB;
            cw[CW_AC_LD]              = 1'b1;
            cw[CW_AC_SRC]             = 1'b1;
          end
          OPC_W'(OP_INAC): begin
            cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_R;
            cw[CW_ALU_MSB:CW_ALU_LSB] = ALU_INC;
            cw[CW_AC_LD]              = 1'b1;
            cw[CW_AC_SRC]             = 1'b1;
          end
          default: cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_NONE;
        endcase
      end
      S_ADDR: begin
        cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_IRAM;
        cw[CW_AR_LD]              = 1'b1;
        cw[CW_PC_INC]             = 1'b1;
        state_nx                  = (iclass == IC_MEM_WR) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_DRAM;
        cw[CW_DRAM_RD]            = 1'b1;
        if (mem_ready) begin
          cw[CW_DR_LD] = 1'b1;
          state_nx     = S_LDAC2;
        end
      end
      S_LDAC2: begin
        cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_DR;
        cw[CW_AC_LD]              = 1'b1;
        state_nx                  = S_FETCH;
      end
      S_MEMWR: begin
        cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_AC;
        cw[CW_DRAM_WR]            = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_JMP: begin
        cw[CW_BUS_MSB:CW_BUS_LSB] = BUS_IRAM;
        cw[CW_PC_LD]              = 1'b1;
        state_nx                  = S_FETCH;
      end
      S_SKIP: begin
        cw[CW_PC_INC] = 1'b1;
        state_nx      = S_FETCH;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: doc/proc_control_unit.md
# proc_control_unit

Multi-cycle sequencer for the 16-bit accumulator processor datapath. Each cycle it emits the 23-bit datapath control word from its state, the instruction register contents and the AC-zero flag. It runs fetch → decode → execute, and stretches data-memory accesses with a ready handshake. It sits beside the datapath in the processor top level and is the only driver of the control word.

## Interface
Parameters:
- `IR_W`, default 16: instruction register width.
- `OPC_W`, default 8: opcode field width, taken from `ir[OPC_W-1:0]`.

Ports:
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: level; leaves IDLE when high.
- `ir`  in  `IR_W`: instruction register output from the datapath.
- `ac_zero`  in  1: AC == 0, from the datapath.
- `mem_ready`  in  1: data memory has completed the current access.
- `control`  out  23: datapath control word.
- `halted`  out  1: high in the HALT state.
- `illegal`  out  1: sticky flag, set on an undefined opcode.

## Operation
Control word fields:
- [7:2] `bus_sel`: 0 none, 1 AR, 2 PC, 3 IR, 4 DR, 5 R, 6 AC, 7 DRAM, 8 IRAM.
- [9:8] `alu_op`: 00 pass, 01 add, 10 sub, 11 inc.
- [10] `pc_inc`.
- [14] `r_ld`, [15] `ar_ld`, [16] `dr_ld`, [17] `ac_ld`, [18] `pc_ld`, [19] `ir_ld`.
- [20] `dram_rd`, [21] `dram_wr`.
- [22] `ac_src`: 1 = ALU result, 0 = bus.
- [1:0] and [13:11] are always 0.

Opcodes:
- 00 NOP
- 01 LDAC (AC←M[next word])
- 02 STAC
- 03 MVACR (R←AC)
- 04 MVRAC (AC←R)
- 05 ADD (AC←AC+R)
- 06 SUB (AC←AC−R)
- 07 INAC
- 08 JUMP (PC←next word)
- 09 JMPZ
- 0A JPNZ
- FF HALT
- Any other value is illegal.

States and the control word asserted in each:
- IDLE: all zero. Go to FETCH when `start` is high.
- FETCH: `bus_sel`=IRAM, `ir_ld`, `pc_inc`. → DECODE.
- DECODE: all zero. Branches on opcode:
  - NOP → FETCH.
  - Register ops → EXEC.
  - LDAC and STAC → ADDR.
  - JUMP → JMP.
  - JMPZ/JPNZ → JMP if the condition holds, else SKIP.
  - HALT → HALT.
- EXEC:
  - MVACR: `bus_sel`=AC, `r_ld`.
  - MVRAC: `bus_sel`=R, `ac_ld`, `ac_src`=0.
  - ADD/SUB/INAC: `bus_sel`=R, `alu_op` as listed, `ac_ld`, `ac_src`=1.
  - → FETCH.
- ADDR: `bus_sel`=IRAM, `ar_ld`, `pc_inc`. → MEMRD for LDAC, MEMWR for STAC.
- MEMRD: `bus_sel`=DRAM, `dram_rd`, and `dr_ld` only when `mem_ready`=1. Stay while `mem_ready`=0, else → LDAC2.
- LDAC2: `bus_sel`=DR, `ac_ld`, `ac_src`=0. → FETCH.
- MEMWR: `bus_sel`=AC, `dram_wr`. Stay while `mem_ready`=0, else → FETCH.
- JMP: `bus_sel`=IRAM, `pc_ld`. → FETCH.
- SKIP: `pc_inc` (steps over the operand word). → FETCH.
- HALT: all zero, `halted`=1. Exits only through reset.

Behaviour rules:
- `ac_zero` is sampled in DECODE only.
- `dram_rd` and `dram_wr` are never asserted together.
- Exactly one `*_ld` may be active per cycle, except `dr_ld` combined with `dram_rd`.

## Timing
- `control` is combinational from the registered state, `ir`, `ac_zero` and `mem_ready`; it is valid for the whole cycle.
- Reset: state IDLE, `control`=0, `halted`=0, `illegal`=0. Assertion mid-instruction (including during a memory wait) returns to IDLE immediately; the next edge sees no access strobe.
- Cycles from FETCH entry to the next FETCH entry, with `mem_ready` tied high:
  - NOP: 2.
  - EXEC ops, JUMP, JMPZ, JPNZ: 3, whether a branch is taken or not.
  - STAC: 4.
  - LDAC: 5.
  - Each low cycle of `mem_ready` adds 1.
- `mem_ready` high in the first MEMRD/MEMWR cycle completes the access in that cycle.
- `start` is ignored outside IDLE.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined: an illegal opcode sets `illegal` and goes DECODE → HALT.
- Undefined: an illegal opcode sets `illegal` and is executed as NOP (DECODE → FETCH).

## Structure
- Package `cu_pkg` holds:
  - opcode constants;
  - `bus_sel` codes;
  - `alu_op` codes;
  - control-word bit index localparams;
  - state enum typedef.
- One combinational sub-module, `cu_decode`, maps opcode to an instruction class (NOP, REG, MEM_RD, MEM_WR, JMP, JZ, JNZ, HALT, ILLEGAL).

## Test plan
- Reset release with `start`=1, IRAM word 0 = 0x0001, operand 0x0040, DRAM[0x40]=0x1234, `mem_ready` high → FETCH, DECODE, ADDR, MEMRD, LDAC2 in 5 cycles; AC=0x1234.
- STAC with `mem_ready` held low for 3 cycles → `dram_wr` high for 4 cycles with `bus_sel`=6; instruction takes 7 cycles.
- JMPZ with AC=0 → PC loaded with the operand. Same test with AC=5 → SKIP, and PC advances by 2 from the opcode address.
- ADD with AC=3, R=4 → EXEC asserts `alu_op`=01, `ac_ld`, `ac_src`; AC=7.
- Opcode 0x55 → `illegal`=1; with the macro defined `halted`=1, without it execution continues at the next word.
- `reset_n` asserted during a MEMRD wait → `control`=0 asynchronously; state IDLE.
